alu_ctrl_decode_stage: RTL and testbench

- Registered decode stage that produces the 4-bit ALU control code and operands consumed by the ALU.
- Takes a fetched RV32I instruction plus register-file read data.
- Decodes opcode/funct3/funct7 into the team ALU code set (0 ADD … 15 BGEU), selects operands and immediate, and holds the result in a single-entry pipeline register.
- Sits between the fetch/regfile stage and the execute stage; uses a valid/ready handshake with flush.

---
 rtl/alu_ctrl_decode_stage_pkg.sv | 76 +++++++
 rtl/alu_ctrl_decode_stage_imm_gen.sv | 31 +++
 rtl/alu_ctrl_decode_stage.sv | 194 +++++++++++++++++++
 tb/tb_alu_ctrl_decode_stage.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_decode_stage_pkg.sv
// Shared RV32I decode definitions: ALU control codes (also used by the ALU),
// base opcodes, immediate formats and small funct3 lookup helpers.
package alu_ctrl_decode_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_BEQ  = 4'd10,
        ALU_BNE  = 4'd11,
        ALU_BLT  = 4'd12,
        ALU_BGE  = 4'd13,
        ALU_BLTU = 4'd14,
        ALU_BGEU = 4'd15
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // alt selects SUB/SRA over ADD/SRL; ignored for the other funct3 values.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_op_e branch_from_funct3(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b000:  op = ALU_BEQ;
            3'b001:  op = ALU_BNE;
            3'b100:  op = ALU_BLT;
            3'b101:  op = ALU_BGE;
            3'b110:  op = ALU_BLTU;
            3'b111:  op = ALU_BGEU;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction, sign-extended to XLEN.
// Opcode bits are not needed here, so only instr[31:7] is taken.
module alu_ctrl_decode_stage_imm_gen
    import alu_ctrl_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_instr,
    input  logic [2:0]      i_imm_type,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = 32'd0;
        case (imm_type_e'(i_imm_type))
            IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'd0};
            IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    assign o_imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

endmodule

// File: rtl/alu_ctrl_decode_stage.sv
// RV32I decode to ALU control/operands, held in a one-entry register (1 cycle latency).
// in_ready = !out_valid || out_ready; a stall holds every output; flush drops held and incoming entries.
module alu_ctrl_decode_stage
    import alu_ctrl_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            is_branch,
    output logic            illegal
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic            w_shift;
    imm_type_e       w_imm_type;
    logic [XLEN-1:0] w_imm;
    alu_op_e         w_alu;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic            w_reg_write;
    logic            w_is_branch;
    logic            w_illegal;
    logic            w_accept;

    logic            r_valid;
    alu_op_e         r_alu_ctrl;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rd;
    logic            r_reg_write;
    logic            r_is_branch;
    logic            r_illegal;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_rd     = instr[11:7];
    assign w_shift  = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    // Immediate format depends on the opcode alone, keeping it off the decode path below.
    always_comb begin
        w_imm_type = IMM_NONE;
        case (w_opcode)
            OP_IMM, OP_LOAD, OP_JALR: w_imm_type = IMM_I;
            OP_STORE:                 w_imm_type = IMM_S;
            OP_BRANCH:                w_imm_type = IMM_B;
            OP_LUI, OP_AUIPC:         w_imm_type = IMM_U;
            OP_JAL:                   w_imm_type = IMM_J;
            default:                  w_imm_type = IMM_NONE;
        endcase
    end

    alu_ctrl_decode_stage_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .i_instr    (instr[31:7]),
        .i_imm_type (w_imm_type),
        .o_imm      (w_imm)
    );

    always_comb begin
        w_alu       = ALU_ADD;
        w_op1       = rs1_data;
        w_op2       = rs2_data;
        w_reg_write = 1'b0;
        w_is_branch = 1'b0;
        w_illegal   = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_illegal   = !((w_funct7 == F7_ZERO) ||
                                ((w_funct7 == F7_ALT) &&
                                 ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
                w_alu       = alu_from_funct3(w_funct3, w_funct7[5]);
                w_reg_write = 1'b1;
            end
            OP_IMM: begin
                // Upper immediate bits are only an encoding field for the shifts.
                w_illegal   = ((w_funct3 == 3'b001) && (w_funct7 != F7_ZERO)) ||
                              ((w_funct3 == 3'b101) && (w_funct7 != F7_ZERO) &&
                               (w_funct7 != F7_ALT));
                w_alu       = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                w_op2       = w_shift ? {{(XLEN-5){1'b0}}, w_imm[4:0]} : w_imm;
                w_reg_write = 1'b1;
            end
            OP_LOAD, OP_JALR: begin
                w_op2       = w_imm;
                w_reg_write = 1'b1;
            end
            OP_STORE: begin
                w_op2       = w_imm;
            end
            OP_LUI: begin
                w_op1       = '0;
                w_op2       = w_imm;
                w_reg_write = 1'b1;
            end
            OP_AUIPC: begin
                w_op1       = pc;
                w_op2       = w_imm;
                w_reg_write = 1'b1;
            end
            OP_JAL: begin
                w_op1       = pc;
                w_op2       = XLEN'(4);
                w_reg_write = 1'b1;
            end
            OP_BRANCH: begin
                w_illegal   = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
                w_alu       = branch_from_funct3(w_funct3);
                w_is_branch = 1'b1;
            end
            default: begin
                w_illegal   = 1'b1;
            end
        endcase
        // Illegal entries still flow to execute, but must be side-effect free.
        if (w_illegal) begin
            w_alu       = ALU_ADD;
            w_op1       = '0;
            w_op2       = '0;
            w_reg_write = 1'b0;
            w_is_branch = 1'b0;
        end
        if (w_rd == 5'd0) begin
            w_reg_write = 1'b0;
        end
    end

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_alu_ctrl  <= ALU_ADD;
            r_op1       <= '0;
            r_op2       <= '0;
            r_imm       <= '0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_is_branch <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                r_alu_ctrl  <= w_alu;
                r_op1       <= w_op1;
                r_op2       <= w_op2;
                r_imm       <= w_imm;
                r_rd        <= w_rd;
                r_reg_write <= w_reg_write;
                r_is_branch <= w_is_branch;
                r_illegal   <= w_illegal;
            end
        end
    end

    assign out_valid = r_valid;
    assign alu_ctrl  = r_alu_ctrl;
    assign op1       = r_op1;
    assign op2       = r_op2;
    assign imm       = r_imm;
    assign rd        = r_rd;
    assign reg_write = r_reg_write;
    assign is_branch = r_is_branch;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Bench for alu_ctrl_decode_stage: directed scenarios plus a randomized
// handshake/decode run against an instruction-level reference model.
module tb_alu_ctrl_decode_stage;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  alu_ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_branch;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    alu_ctrl_decode_stage #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .op1       (op1),
        .op2       (op2),
        .imm       (imm),
        .rd        (rd),
        .reg_write (reg_write),
        .is_branch (is_branch),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  alu;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        br;
        logic        ill;
        logic        chk_imm;
        logic        chk_ops;
    } exp_t;

    // Position of funct3 in the ADD..AND list of codes, skipping the SUB slot.
    function automatic int rcode(input logic [2:0] f3);
        if (f3 == 3'd0) return 0;
        if (f3 <= 3'd5) return int'(f3) + 1;
        return int'(f3) + 2;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic signed [31:0] t;
        logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
        logic legal, writes, alt, shift;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        t = {ins[31:20], 20'd0};                                       imm_i = t >>> 20;
        t = {ins[31:25], ins[11:7], 20'd0};                            imm_s = t >>> 20;
        t = {ins[31], ins[7], ins[30:25], ins[11:8], 20'd0};           imm_b = t >>> 19;
        t = {ins[31], ins[19:12], ins[20], ins[30:21], 12'd0};         imm_j = t >>> 11;
        imm_u = {ins[31:12], 12'd0};
        e = '0;
        e.rd = ins[11:7];
        e.chk_imm = 1'b1;
        e.chk_ops = 1'b1;
        legal = 1'b1;
        writes = 1'b0;
        case (opc)
            7'h33: begin
                alt = (f7 == 7'h20);
                legal = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
                e.alu = 4'(rcode(f3) + (alt ? 1 : 0));
                e.op1 = a; e.op2 = b; writes = 1'b1; e.chk_imm = 1'b0;
            end
            7'h13: begin
                shift = (f3 == 3'd1) || (f3 == 3'd5);
                alt = (f3 == 3'd5) && (f7 == 7'h20);
                legal = !shift || (f7 == 7'h00) || alt;
                e.alu = 4'(rcode(f3) + (alt ? 1 : 0));
                e.op1 = a; e.op2 = shift ? {27'd0, ins[24:20]} : imm_i;
                e.imm = imm_i; writes = 1'b1;
            end
            7'h03: begin e.op1 = a; e.op2 = imm_i; e.imm = imm_i; writes = 1'b1; end
            7'h23: begin e.op1 = a; e.op2 = imm_s; e.imm = imm_s; end
            7'h67: begin e.op1 = a; e.op2 = imm_i; e.imm = imm_i; writes = 1'b1; end
            7'h37: begin e.op1 = 32'd0; e.op2 = imm_u; writes = 1'b1; e.chk_imm = 1'b0; end
            7'h17: begin e.op1 = p; e.op2 = imm_u; writes = 1'b1; e.chk_imm = 1'b0; end
            7'h6f: begin e.op1 = p; e.op2 = 32'd4; e.imm = imm_j; writes = 1'b1; end
            7'h63: begin
                legal = (f3 != 3'd2) && (f3 != 3'd3);
                e.alu = (f3 < 3'd2) ? 4'(10 + int'(f3)) : 4'(8 + int'(f3));
                e.op1 = a; e.op2 = b; e.imm = imm_b; e.br = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.alu = 4'd0; e.br = 1'b0; writes = 1'b0; e.ill = 1'b1;
            e.chk_imm = 1'b0; e.chk_ops = 1'b0;
        end
        e.rw = writes && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0] f7;
        int k;
        w = $urandom;
        k = $urandom_range(0, 10);
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1, 2:    f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        case (k)
            0:  w = {f7, w[24:7], 7'h33};
            1:  w = {f7, w[24:7], 7'h13};
            2:  w[6:0] = 7'h03;
            3:  w[6:0] = 7'h23;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h37;
            6:  w[6:0] = 7'h17;
            7:  w[6:0] = 7'h6f;
            8:  w[6:0] = 7'h67;
            9:  w[6:0] = 7'($urandom);
            default: w[6:0] = 7'h13;
        endcase
        return w;
    endfunction

    task automatic send(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        instr = i; pc = p; rs1_data = a; rs2_data = b;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (out_valid !== 1'b0 || alu_ctrl !== 4'd0 || op1 !== 32'd0 || op2 !== 32'd0 ||
            imm !== 32'd0 || rd !== 5'd0 || reg_write !== 1'b0 || is_branch !== 1'b0 ||
            illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b alu=%0d op1=%h op2=%h imm=%h rd=%0d rw=%b br=%b ill=%b, want all 0",
                     out_valid, alu_ctrl, op1, op2, imm, rd, reg_write, is_branch, illegal);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        send(32'h002081B3, 32'h100, 32'd5, 32'd7);
        n_cmp++;
        if (out_valid !== 1'b1 || alu_ctrl !== 4'd0 || op1 !== 32'd5 || op2 !== 32'd7 ||
            rd !== 5'd3 || reg_write !== 1'b1 || is_branch !== 1'b0 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL add: got v=%b alu=%0d op1=%0d op2=%0d rd=%0d rw=%b br=%b ill=%b, want 1/0/5/7/3/1/0/0",
                     out_valid, alu_ctrl, op1, op2, rd, reg_write, is_branch, illegal);
        end
    endtask

    task automatic test_sub_srai();
        send(32'h402081B3, 32'h104, 32'd5, 32'd7);
        n_cmp++;
        if (alu_ctrl !== 4'd1 || op1 !== 32'd5 || op2 !== 32'd7 || reg_write !== 1'b1) begin
            n_err++;
            $display("FAIL sub: got alu=%0d op1=%0d op2=%0d rw=%b, want 1/5/7/1", alu_ctrl, op1, op2, reg_write);
        end
        send(32'h40335293, 32'h108, 32'hF000_0000, 32'd99);
        n_cmp++;
        if (alu_ctrl !== 4'd7 || op1 !== 32'hF000_0000 || op2 !== 32'd3 || rd !== 5'd5 ||
            reg_write !== 1'b1 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL srai: got alu=%0d op1=%h op2=%0d rd=%0d rw=%b ill=%b, want 7/f0000000/3/5/1/0",
                     alu_ctrl, op1, op2, rd, reg_write, illegal);
        end
    endtask

    task automatic test_branch_lui();
        send(32'h0020D463, 32'h200, 32'd1, 32'd2);
        n_cmp++;
        if (alu_ctrl !== 4'd13 || is_branch !== 1'b1 || imm !== 32'd8 || reg_write !== 1'b0 ||
            op1 !== 32'd1 || op2 !== 32'd2) begin
            n_err++;
            $display("FAIL bge: got alu=%0d br=%b imm=%0d rw=%b op1=%0d op2=%0d, want 13/1/8/0/1/2",
                     alu_ctrl, is_branch, imm, reg_write, op1, op2);
        end
        send(32'h123450B7, 32'h204, 32'hDEAD, 32'hBEEF);
        n_cmp++;
        if (alu_ctrl !== 4'd0 || op1 !== 32'd0 || op2 !== 32'h12345000 || rd !== 5'd1 ||
            reg_write !== 1'b1) begin
            n_err++;
            $display("FAIL lui: got alu=%0d op1=%h op2=%h rd=%0d rw=%b, want 0/0/12345000/1/1",
                     alu_ctrl, op1, op2, rd, reg_write);
        end
        send(32'h00500013, 32'h208, 32'd0, 32'd0);
        n_cmp++;
        if (reg_write !== 1'b0 || rd !== 5'd0 || op2 !== 32'd5) begin
            n_err++;
            $display("FAIL rd0_no_write: got rw=%b rd=%0d op2=%0d, want 0/0/5", reg_write, rd, op2);
        end
    endtask

    task automatic test_illegal();
        send(32'h0000207F, 32'h300, 32'd1, 32'd2);
        n_cmp++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_ctrl !== 4'd0 || reg_write !== 1'b0 ||
            is_branch !== 1'b0) begin
            n_err++;
            $display("FAIL bad_opcode: got v=%b ill=%b alu=%0d rw=%b br=%b, want 1/1/0/0/0",
                     out_valid, illegal, alu_ctrl, reg_write, is_branch);
        end
        send(32'h0020A463, 32'h304, 32'd1, 32'd2);
        n_cmp++;
        if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_ctrl !== 4'd0 || reg_write !== 1'b0 ||
            is_branch !== 1'b0) begin
            n_err++;
            $display("FAIL branch_f3_010: got v=%b ill=%b alu=%0d rw=%b br=%b, want 1/1/0/0/0",
                     out_valid, illegal, alu_ctrl, reg_write, is_branch);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        instr = 32'h402081B3; rs1_data = 32'd9; rs2_data = 32'd4;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || alu_ctrl !== 4'd0 || op1 !== 32'd5 || op2 !== 32'd7 ||
                rd !== 5'd3 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got v=%b alu=%0d op1=%0d op2=%0d rd=%0d rdy=%b, want 1/0/5/7/3/0",
                         c, out_valid, alu_ctrl, op1, op2, rd, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || alu_ctrl !== 4'd1 || op1 !== 32'd9 || op2 !== 32'd4) begin
            n_err++;
            $display("FAIL back_to_back: got v=%b alu=%0d op1=%0d op2=%0d, want 1/1/9/4",
                     out_valid, alu_ctrl, op1, op2);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        instr = 32'h002081B3; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b1; instr = 32'h123450B7; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_kill: got out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_drop_input: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        instr = 32'h40335293; rs1_data = 32'd77; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || imm !== 32'h403) begin
            n_err++;
            $display("FAIL pre_reset_hold: got v=%b imm=%h want 1/403", out_valid, imm);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || alu_ctrl !== 4'd0 || op1 !== 32'd0 || op2 !== 32'd0 ||
            imm !== 32'd0 || rd !== 5'd0 || reg_write !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b alu=%0d op1=%h op2=%h imm=%h rd=%0d rw=%b, want all 0",
                     out_valid, alu_ctrl, op1, op2, imm, rd, reg_write);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic m_valid;
        exp_t m_e;
        exp_t nx;
        logic acc;
        m_valid = 1'b0;
        m_e = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== m_valid) begin
                n_err++;
                $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, m_valid);
            end
            if (m_valid) begin
                n_cmp++;
                if (alu_ctrl !== m_e.alu || rd !== m_e.rd || reg_write !== m_e.rw ||
                    is_branch !== m_e.br || illegal !== m_e.ill) begin
                    n_err++;
                    $display("FAIL rnd_ctrl[%0d]: got alu=%0d rd=%0d rw=%b br=%b ill=%b want %0d/%0d/%b/%b/%b",
                             c, alu_ctrl, rd, reg_write, is_branch, illegal,
                             m_e.alu, m_e.rd, m_e.rw, m_e.br, m_e.ill);
                end
                if (m_e.chk_ops) begin
                    n_cmp++;
                    if (op1 !== m_e.op1 || op2 !== m_e.op2) begin
                        n_err++;
                        $display("FAIL rnd_ops[%0d]: got op1=%h op2=%h want %h %h",
                                 c, op1, op2, m_e.op1, m_e.op2);
                    end
                end
                if (m_e.chk_imm) begin
                    n_cmp++;
                    if (imm !== m_e.imm) begin
                        n_err++;
                        $display("FAIL rnd_imm[%0d]: got %h want %h", c, imm, m_e.imm);
                    end
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            instr     = rand_instr();
            pc        = $urandom;
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            #1;
            n_cmp++;
            if (in_ready !== (!m_valid || out_ready)) begin
                n_err++;
                $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, in_ready, !m_valid || out_ready);
            end
            acc = in_valid && (!m_valid || out_ready) && !flush;
            nx = model(instr, pc, rs1_data, rs2_data);
            if (flush) begin
                m_valid = 1'b0;
            end else if (acc) begin
                m_valid = 1'b1;
                m_e = nx;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_srai();
        test_branch_lui();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
